// File: rtl/aes_pkg.sv
// Shared AES constants, byte/word helpers and types for the iterative cipher.
// Words are logic [31:0] with byte0 in [31:24]; blocks are logic [0:127] with byte0 in [0:7].
package aes_pkg;

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} fsm_t;
  typedef logic [0:127] state_t;

  // Row-major S-box, entry n occupies bits [8n : 8n+7].
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    r = 8'h00;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// State byte index is row + 4*column, as in FIPS-197.
module aes_round
  import aes_pkg::*;
(
  input  logic [0:127] i_state,
  input  logic [0:127] i_rkey,
  input  logic         i_last,
  output logic [0:127] o_state
);

  logic [7:0] w_sb [16];
  logic [7:0] w_sr [16];
  logic [7:0] w_mc [16];
  logic [31:0] w_col;
  logic [31:0] w_mix;

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  always_comb begin
    w_sb = '{default: 8'h00};
    w_sr = '{default: 8'h00};
    w_mc = '{default: 8'h00};
    w_col = '0;
    w_mix = '0;
    o_state = '0;
    for (int b = 0; b < 16; b++) begin
      w_sb[b] = sbox(i_state[8*b +: 8]);
    end
    // Row r rotates left by r columns.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_sr[r + 4*c] = w_sb[r + 4*((c + r) % 4)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      w_col = {w_sr[4*c], w_sr[4*c+1], w_sr[4*c+2], w_sr[4*c+3]};
      w_mix = mix_column(w_col);
      w_mc[4*c]   = w_mix[31:24];
      w_mc[4*c+1] = w_mix[23:16];
      w_mc[4*c+2] = w_mix[15:8];
      w_mc[4*c+3] = w_mix[7:0];
    end
    for (int b = 0; b < 16; b++) begin
      o_state[8*b +: 8] = (i_last ? w_sr[b] : w_mc[b]) ^ i_rkey[8*b +: 8];
    end
  end

endmodule

// File: rtl/aes_cipher_seq.sv
// Iterative AES encryptor: expands the key one word per cycle into a local store,
// then runs one round per cycle through a shared aes_round unit.
module aes_cipher_seq
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10,
  localparam int Nkb = Nk * 32,
  localparam int Nw = 4 * (Nr + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [0:127]   in,
  input  logic [0:Nkb-1] key,
  input  logic           key_reuse,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [0:127]   out,
  output logic           busy
);

  localparam int IW = $clog2(Nw);
  localparam int RW = $clog2(Nr + 1);

  if (Nr != Nk + 6) begin : g_bad_params
    $error("aes_cipher_seq: Nr (%0d) must equal Nk+6 (Nk=%0d)", Nr, Nk);
  end

  fsm_t          r_fsm;
  fsm_t          w_fsm_next;
  state_t        r_state;
  state_t        r_out;
  logic [31:0]   r_w [0:Nw-1];
  logic [IW-1:0] r_i;
  logic [RW-1:0] r_r;
  logic [2:0]    r_kpos;
  logic [3:0]    r_rc;
  logic          r_sched_valid;

  logic          w_accept;
  logic          w_reuse;
  logic          w_kexp_last;
  logic          w_round_last;
  logic [31:0]   w_prev;
  logic [31:0]   w_back;
  logic [31:0]   w_temp;
  logic [31:0]   w_new;
  logic [IW-1:0] w_rk_base;
  state_t        w_rkey;
  state_t        w_round_out;

  assign w_accept     = (r_fsm == IDLE) && in_valid;
  assign w_reuse      = key_reuse && r_sched_valid;
  assign w_kexp_last  = (r_i == IW'(Nw - 1));
  assign w_round_last = (r_r == RW'(Nr));

  assign w_prev    = r_w[r_i - IW'(1)];
  assign w_back    = r_w[r_i - IW'(Nk)];
  assign w_rk_base = IW'({r_r, 2'b00});
  assign w_rkey    = {r_w[w_rk_base], r_w[w_rk_base + IW'(1)],
                      r_w[w_rk_base + IW'(2)], r_w[w_rk_base + IW'(3)]};

  // r_kpos tracks i mod Nk and r_rc tracks i / Nk, so no divider is needed.
  always_comb begin
    w_temp = w_prev;
    if (r_kpos == 3'd0) begin
      w_temp = sub_word(rot_word(w_prev)) ^ {rcon(r_rc), 24'h000000};
    end else if (Nk == 8 && r_kpos == 3'd4) begin
      w_temp = sub_word(w_prev);
    end
    w_new = w_back ^ w_temp;
  end

  aes_round u_round (
    .i_state (r_state),
    .i_rkey  (w_rkey),
    .i_last  (w_round_last),
    .o_state (w_round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      IDLE:    if (in_valid) w_fsm_next = w_reuse ? ROUND : KEXP;
      KEXP:    if (w_kexp_last) w_fsm_next = ROUND;
      ROUND:   if (w_round_last) w_fsm_next = DONE;
      DONE:    if (out_ready) w_fsm_next = IDLE;
      default: w_fsm_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_fsm == IDLE);
    out_valid = (r_fsm == DONE);
    busy      = (r_fsm == KEXP) || (r_fsm == ROUND);
  end

  assign out = r_out;

  // Any reset drops sched_valid, so a partially built schedule is never reused.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= '0;
      r_out         <= '0;
      r_sched_valid <= 1'b0;
      r_i           <= '0;
      r_r           <= '0;
      r_kpos        <= '0;
      r_rc          <= '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_state <= in;
            r_r     <= '0;
            if (!w_reuse) begin
              r_sched_valid <= 1'b0;
              r_i           <= IW'(Nk);
              r_kpos        <= '0;
              r_rc          <= 4'd1;
            end
          end
        end
        KEXP: begin
          r_i <= r_i + IW'(1);
          if (r_kpos == 3'(Nk - 1)) begin
            r_kpos <= '0;
            r_rc   <= r_rc + 4'd1;
          end else begin
            r_kpos <= r_kpos + 3'd1;
          end
          if (w_kexp_last) begin
            r_sched_valid <= 1'b1;
            r_r           <= '0;
          end
        end
        ROUND: begin
          r_state <= (r_r == '0) ? (r_state ^ w_rkey) : w_round_out;
          r_r     <= r_r + RW'(1);
          if (w_round_last) begin
            r_out <= w_round_out;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && !w_reuse) begin
      for (int k = 0; k < Nk; k++) begin
        r_w[k] <= key[32*k +: 32];
      end
    end else if (r_fsm == KEXP) begin
      r_w[r_i] <= w_new;
    end
  end

endmodule
